// File: rtl/urp_pcie_pkg.sv
// urp_pcie_pkg: shared widths and types for the URP PCIe egress path
package urp_pcie_pkg;
  localparam int URP_PCIE_DATA_SIZE = 224;
  typedef logic [URP_PCIE_DATA_SIZE-1:0] urp_pcie_data_t;
endpackage

// File: rtl/urp_pcie_fifo_mem.sv
// urp_pcie_fifo_mem: unreset register array, one write port, asynchronous read port
module urp_pcie_fifo_mem
  import urp_pcie_pkg::*;
#(
  parameter int DATA_SIZE = URP_PCIE_DATA_SIZE,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_SIZE-1:0]     wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_SIZE-1:0]     rdata
);
  logic [DATA_SIZE-1:0] mem [DEPTH];
  // write the accepted word into its slot
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/urp_pcie_egress_fifo.sv
// urp_pcie_egress_fifo: FWFT elastic buffer behind the PCIe arbiter; level stats under URP_PCIE_FIFO_STATS_EN
module urp_pcie_egress_fifo
  import urp_pcie_pkg::*;
#(
  parameter int DATA_SIZE = URP_PCIE_DATA_SIZE,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   src_valid_i,
  output logic                   src_ready_o,
  input  logic [DATA_SIZE-1:0]   src_data_i,
  output logic                   dst_valid_o,
  input  logic                   dst_ready_i,
  output logic [DATA_SIZE-1:0]   dst_data_o
`ifdef URP_PCIE_FIFO_STATS_EN
  ,
  output logic [$clog2(DEPTH):0] level_o,
  output logic [$clog2(DEPTH):0] max_level_o
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count, count_next;
  logic push, pop;
  logic [DATA_SIZE-1:0] rdata;
  assign src_ready_o = !rst && count != FULL;
  assign dst_valid_o = count != '0;
  assign push = src_valid_i && src_ready_o;
  assign pop = dst_valid_o && dst_ready_i;
  assign dst_data_o = dst_valid_o ? rdata : '0;
  // occupancy after this edge
  always_comb count_next = count + (AW+1)'(push) - (AW+1)'(pop);
  // pointers advance independently; occupancy tracks push/pop balance
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count_next;
    end
  urp_pcie_fifo_mem #(.DATA_SIZE(DATA_SIZE), .DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .we(push),
    .waddr(wr_ptr),
    .wdata(src_data_i),
    .raddr(rd_ptr),
    .rdata(rdata)
  );
`ifdef URP_PCIE_FIFO_STATS_EN
  assign level_o = count;
  // high-water mark of occupancy since reset
  always_ff @(posedge clk or posedge rst)
    if (rst) max_level_o <= '0;
    else if (count_next > max_level_o) max_level_o <= count_next;
`endif
endmodule
